skolem_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a combinational Skolem-function datapath of the xor_N_M family (N universal inputs, M existential outputs). It drives every input assignment 0 … 2^N−1 into the Skolem block and waits a programmable settle time. It then checks that the XOR of all outputs equals the XOR of all inputs, and reports the pass/fail count and the first failing vector. It sits between a test/config host and an instantiated SKOLEMFORMULA netlist, one instance per controller.

---
 rtl/skolem_sweep_if.sv | 27 ++
 rtl/skolem_sweep_ctrl.sv | 111 +++++++++++
 tb/tb_skolem_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/skolem_sweep_if.sv
// Host/Skolem-side bundle for the sweep controller: host control, status,
// and the vector path to and from the Skolem datapath under test.
interface skolem_sweep_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 2
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   skf_in;
    logic [N_OUT-1:0]  skf_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     fail_count;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_vec;

    modport master (
        output start, abort, skf_out,
        input  skf_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, abort, skf_out,
        output skf_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer for an xor_N_M Skolem datapath: walks every input
// vector, waits SETTLE cycles, and checks parity(outputs) == parity(inputs).
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep are held
// WAIT  | current vector applied, counting down the settle time
// CHECK | sampling skf_out against the parity relation for the current vector
// DONE  | one-cycle completion pulse, pass is valid
module skolem_sweep_ctrl #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input logic          clk,
    input logic          rst,
    skolem_sweep_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // With no settle time the vector is checked in the cycle it is applied.
    localparam logic [1:0]      ST_ENTRY   = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC   = '1;

    logic [1:0]      state;
    logic [3:0]      wait_cnt;
    logic [N_IN-1:0] vec;
    logic [N_IN:0]   fcnt;
    logic            ffv;
    logic [N_IN-1:0] ffvec;
    logic            pass_r;

    logic            vec_fail;
    logic [N_IN:0]   fcnt_upd;

    assign vec_fail = (^vec) != (^bus.skf_out);
    assign fcnt_upd = fcnt + (N_IN+1)'(vec_fail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            vec      <= '0;
            fcnt     <= '0;
            ffv      <= 1'b0;
            ffvec    <= '0;
            pass_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        vec      <= '0;
                        fcnt     <= '0;
                        ffv      <= 1'b0;
                        ffvec    <= '0;
                        pass_r   <= 1'b0;
                        wait_cnt <= SETTLE_CNT;
                        state    <= ST_ENTRY;
                    end
                end
                ST_WAIT: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt <= 4'd1) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // An abort discards this cycle's check entirely.
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        fcnt <= fcnt_upd;
                        if (vec_fail && !ffv) begin
                            ffv   <= 1'b1;
                            ffvec <= vec;
                        end
                        if (vec == LAST_VEC) begin
                            pass_r <= (fcnt_upd == '0);
                            state  <= ST_DONE;
                        end else begin
                            vec      <= vec + N_IN'(1);
                            wait_cnt <= SETTLE_CNT;
                            state    <= ST_ENTRY;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.skf_in           = vec;
    assign bus.busy             = (state == ST_WAIT) || (state == ST_CHECK);
    assign bus.done             = (state == ST_DONE);
    assign bus.pass             = pass_r;
    assign bus.fail_count       = fcnt;
    assign bus.first_fail_valid = ffv;
    assign bus.first_fail_vec   = ffvec;
endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: SETTLE=1 instance checked every cycle against a
// timing-formula model, plus SETTLE=0 and SETTLE=3 instances for latency.
module tb_skolem_sweep_ctrl;
    localparam int NI = 5;
    localparam int S  = 1;
    localparam int L  = (1 << NI) * (S + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic cmp_en = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    skolem_sweep_if #(.N_IN(5), .N_OUT(2)) bus1 ();
    skolem_sweep_if #(.N_IN(5), .N_OUT(2)) bus0 ();
    skolem_sweep_if #(.N_IN(5), .N_OUT(2)) bus3 ();

    skolem_sweep_ctrl #(.N_IN(5), .N_OUT(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    skolem_sweep_ctrl #(.N_IN(5), .N_OUT(2), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    skolem_sweep_ctrl #(.N_IN(5), .N_OUT(2), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // mode 0: correct xor_5_2, 1: outputs stuck 00, 2: y0 inverted for x >= 20
    function automatic logic [1:0] skolem(logic [4:0] x, logic [1:0] md);
        logic [1:0] y;
        y = {x[0], ^x[4:1]};
        if (md == 2'd1) y = 2'b00;
        else if (md == 2'd2 && x >= 5'd20) y[0] = ~y[0];
        return y;
    endfunction

    function automatic logic vec_fails(int k, logic [1:0] md);
        logic [4:0] x;
        x = k[4:0];
        return (^x) != (^skolem(x, md));
    endfunction

    always_comb bus1.skf_out = skolem(bus1.skf_in, mode);
    always_comb bus0.skf_out = skolem(bus0.skf_in, 2'd0);
    always_comb bus3.skf_out = skolem(bus3.skf_in, 2'd0);

    typedef struct packed {
        logic       active;
        logic [7:0] t;
        logic [4:0] skf;
        logic [5:0] fc;
        logic       ffv;
        logic [4:0] ffvec;
        logic       pass;
    } mdl_t;

    mdl_t m = '0;

    // t counts cycles since the accepted start edge: cycle t is busy for 1..L,
    // t = L+1 is the done cycle, vector k is checked at t = 1+S+k*(S+1).
    function automatic mdl_t mdl_next(mdl_t cur, logic r, logic st, logic ab, logic [1:0] md);
        mdl_t n;
        int k;
        int t;
        n = cur;
        t = int'(cur.t);
        if (r) begin
            n = '0;
        end else if (cur.active) begin
            if (t <= L && ab) begin
                n.active = 1'b0;
            end else if (t == L + 1) begin
                n.active = 1'b0;
            end else begin
                if (t >= 1 + S && ((t - 1 - S) % (S + 1)) == 0) begin
                    k = (t - 1 - S) / (S + 1);
                    if (vec_fails(k, md)) begin
                        n.fc = cur.fc + 6'd1;
                        if (!cur.ffv) begin
                            n.ffv   = 1'b1;
                            n.ffvec = k[4:0];
                        end
                    end
                    if (k == (1 << NI) - 1) n.pass = (n.fc == 6'd0);
                end
                n.t = cur.t + 8'd1;
                if (t + 1 <= L) n.skf = 5'(t / (S + 1));
            end
        end else if (st) begin
            n = '0;
            n.active = 1'b1;
            n.t = 8'd1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= mdl_next(m, rst, bus1.start, bus1.abort, mode);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", int'(bus1.busy), int'(m.active && m.t >= 8'd1 && int'(m.t) <= L));
            chk("m_done", int'(bus1.done), int'(m.active && int'(m.t) == L + 1));
            chk("m_skf_in", int'(bus1.skf_in), int'(m.skf));
            chk("m_fail_count", int'(bus1.fail_count), int'(m.fc));
            chk("m_ffv", int'(bus1.first_fail_valid), int'(m.ffv));
            chk("m_ffvec", int'(bus1.first_fail_vec), int'(m.ffvec));
            chk("m_pass", int'(bus1.pass), int'(m.pass));
        end
    end

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: bus0.start = v;
            3: bus3.start = v;
            default: bus1.start = v;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return bus0.done;
            3: return bus3.done;
            default: return bus1.done;
        endcase
    endfunction

    // Returns n = cycle index (relative to the start edge) where done was seen.
    task automatic run_sweep(input int sel, input bit noisy, output int n);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        n = 1;
        if (sel == 1) begin
            chk("start_busy", int'(bus1.busy), 1);
            chk("start_pass_clr", int'(bus1.pass), 0);
            chk("start_fc_clr", int'(bus1.fail_count), 0);
            chk("start_skf0", int'(bus1.skf_in), 0);
        end
        while (!get_done(sel) && n < 400) begin
            @(negedge clk);
            n++;
            set_start(sel, noisy && (n % 7 == 3));
        end
        set_start(sel, 1'b0);
    endtask

    initial begin
        int n;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_busy", int'(bus1.busy), 0);
        chk("rst_fc", int'(bus1.fail_count), 0);
        chk("rst_pass", int'(bus1.pass), 0);
        rst = 1'b0;
        @(negedge clk);

        mode = 2'd0;
        run_sweep(1, 1'b0, n);
        chk("ok_latency", n, 65);
        chk("ok_pass", int'(bus1.pass), 1);
        chk("ok_fc", int'(bus1.fail_count), 0);
        chk("ok_ffv", int'(bus1.first_fail_valid), 0);
        chk("ok_busy_in_done", int'(bus1.busy), 0);

        mode = 2'd1;
        run_sweep(1, 1'b0, n);
        chk("stuck_latency", n, 65);
        chk("stuck_fc", int'(bus1.fail_count), 16);
        chk("stuck_ffvec", int'(bus1.first_fail_vec), 1);
        chk("stuck_pass", int'(bus1.pass), 0);

        mode = 2'd2;
        run_sweep(1, 1'b0, n);
        chk("hi_fc", int'(bus1.fail_count), 12);
        chk("hi_ffvec", int'(bus1.first_fail_vec), 20);
        chk("hi_pass", int'(bus1.pass), 0);

        // abort during the CHECK of vector 10 (cycle T+22)
        mode = 2'd1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (21) @(negedge clk);
        chk("abort_pre_vec", int'(bus1.skf_in), 10);
        chk("abort_pre_fc", int'(bus1.fail_count), 5);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        chk("abort_busy", int'(bus1.busy), 0);
        chk("abort_done", int'(bus1.done), 0);
        chk("abort_fc", int'(bus1.fail_count), 5);
        chk("abort_pass", int'(bus1.pass), 0);
        chk("abort_ffvec", int'(bus1.first_fail_vec), 1);
        run_sweep(1, 1'b0, n);
        chk("post_abort_fc", int'(bus1.fail_count), 16);

        // repeated start pulses mid-sweep, then back-to-back sweep
        mode = 2'd0;
        run_sweep(1, 1'b1, n);
        chk("noisy_latency", n, 65);
        chk("noisy_pass", int'(bus1.pass), 1);
        mode = 2'd1;
        run_sweep(1, 1'b0, n);
        chk("b2b_latency", n, 65);
        chk("b2b_fc", int'(bus1.fail_count), 16);

        // reset mid-sweep at T+20
        mode = 2'd2;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", int'(bus1.busy), 0);
        chk("rst_mid_skf", int'(bus1.skf_in), 0);
        chk("rst_mid_fc", int'(bus1.fail_count), 0);
        chk("rst_mid_ffv", int'(bus1.first_fail_valid), 0);
        repeat (60) @(negedge clk);
        chk("rst_mid_no_done", int'(bus1.done), 0);

        run_sweep(0, 1'b0, n);
        chk("settle0_latency", n, 33);
        chk("settle0_pass", int'(bus0.pass), 1);
        run_sweep(3, 1'b0, n);
        chk("settle3_latency", n, 129);
        chk("settle3_pass", int'(bus3.pass), 1);
        chk("settle3_fc", int'(bus3.fail_count), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
